// File: rtl/i2s_transmitter.sv
// -----------------------------------------------------------------------------
// i2s_transmitter
// Serialises stereo PCM sample pairs onto a standard I2S link. Each frame is
// 64 sclk periods: the left word starts at bit position 0 and the right word at
// position 32, MSB first. Unused bits are sent as zero. Word select leads each
// channel MSB by one bit clock.
//
// A one-deep holding buffer decouples the upstream handshake from the frame
// timing. The buffer is copied into the shift registers at every frame start.
// If the buffer is empty at that point, a zero frame is sent and underrun is
// flagged.
//
// Ports
//   clk_in          system clock
//   rst_in          asynchronous reset, active low
//   left_in         left sample (two's complement), WIDTH bits
//   right_in        right sample (two's complement), WIDTH bits
//   valid_in        sample pair offered
//   ready_out       holding buffer empty; pair taken when valid_in && ready_out
//   sclk_out        I2S bit clock (clk_in / (2*CLK_DIV))
//   ws_out          I2S word select, 0 = left, 1 = right
//   sdata_out       I2S serial data, MSB first
//   frame_start_out one-cycle pulse when bit position 0 begins
//   underrun_out    one-cycle pulse when a frame begins with no buffered pair
// -----------------------------------------------------------------------------
module i2s_transmitter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CLK_DIV = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] left_in,
    input  logic [WIDTH-1:0] right_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             sclk_out,
    output logic             ws_out,
    output logic             sdata_out,
    output logic             frame_start_out,
    output logic             underrun_out
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned POS_W = 6;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(63);
    localparam logic [POS_W-1:0] POS_R0    = POS_W'(32);
    localparam logic [POS_W-1:0] WS_RISE   = POS_W'(31);
    localparam logic [POS_W-1:0] WS_FALL   = POS_W'(62);
    // One bit wider than the position so that WIDTH = 32 (end = 64) fits.
    localparam logic [POS_W:0]   L_END     = (POS_W + 1)'(WIDTH);
    localparam logic [POS_W:0]   R_END     = (POS_W + 1)'(32 + WIDTH);

    // Bit-clock generation
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             sclk_q, sclk_d;

    // Frame position and serial outputs
    logic [POS_W-1:0] pos_q, pos_d;
    logic             ws_q, ws_d;
    logic             sdata_q, sdata_d;
    logic             frame_start_q, frame_start_d;
    logic             underrun_q, underrun_d;

    // Holding buffer
    logic [WIDTH-1:0] hold_l_q, hold_l_d;
    logic [WIDTH-1:0] hold_r_q, hold_r_d;
    logic             hold_full_q, hold_full_d;

    // Channel shift registers; the MSB is the next bit to send
    logic [WIDTH-1:0] shift_l_q, shift_l_d;
    logic [WIDTH-1:0] shift_r_q, shift_r_d;

    // Combinational helpers
    logic             div_wrap;
    logic             fall_evt;
    logic             accept;
    logic [POS_W-1:0] pos_nxt;
    logic [WIDTH-1:0] src_l;
    logic [WIDTH-1:0] src_r;

    // Next-state logic for the divider, framing, buffer and serialiser
    always_comb begin
        div_cnt_d     = div_cnt_q;
        sclk_d        = sclk_q;
        pos_d         = pos_q;
        ws_d          = ws_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        hold_full_d   = hold_full_q;
        shift_l_d     = shift_l_q;
        shift_r_d     = shift_r_q;
        pos_nxt       = pos_q + POS_W'(1);
        src_l         = shift_l_q;
        src_r         = shift_r_q;

        div_wrap = (div_cnt_q == DIV_LAST);
        fall_evt = div_wrap && sclk_q;
        // Only an empty buffer accepts, so an accept can never land on the
        // same cycle as a buffer-to-shifter load (which needs a full buffer).
        accept   = valid_in && !hold_full_q;

        div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
        if (div_wrap) begin
            sclk_d = ~sclk_q;
        end

        if (accept) begin
            hold_l_d    = left_in;
            hold_r_d    = right_in;
            hold_full_d = 1'b1;
        end

        if (fall_evt) begin
            pos_d = pos_nxt;
            ws_d  = (pos_nxt >= WS_RISE) && (pos_nxt <= WS_FALL);

            // Frame boundary: take the buffered pair or fall back to silence.
            if (pos_nxt == '0) begin
                frame_start_d = 1'b1;
                if (hold_full_q) begin
                    src_l       = hold_l_q;
                    src_r       = hold_r_q;
                    hold_full_d = 1'b0;
                end else begin
                    src_l      = '0;
                    src_r      = '0;
                    underrun_d = 1'b1;
                end
            end

            shift_l_d = src_l;
            shift_r_d = src_r;
            sdata_d   = 1'b0;
            if ({1'b0, pos_nxt} < L_END) begin
                sdata_d   = src_l[WIDTH-1];
                shift_l_d = src_l << 1;
            end else if ((pos_nxt >= POS_R0) && ({1'b0, pos_nxt} < R_END)) begin
                sdata_d   = src_r[WIDTH-1];
                shift_r_d = src_r << 1;
            end
        end
    end

    // State registers; reset parks the position at 63 so the first falling
    // edge after release opens a fresh frame at position 0.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            div_cnt_q     <= '0;
            sclk_q        <= 1'b0;
            pos_q         <= POS_LAST;
            ws_q          <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            hold_full_q   <= 1'b0;
            shift_l_q     <= '0;
            shift_r_q     <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            sclk_q        <= sclk_d;
            pos_q         <= pos_d;
            ws_q          <= ws_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            hold_full_q   <= hold_full_d;
            shift_l_q     <= shift_l_d;
            shift_r_q     <= shift_r_d;
        end
    end

    assign ready_out       = ~hold_full_q;
    assign sclk_out        = sclk_q;
    assign ws_out          = ws_q;
    assign sdata_out       = sdata_q;
    assign frame_start_out = frame_start_q;
    assign underrun_out    = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// -----------------------------------------------------------------------------
// tb_i2s_transmitter
// Directed/randomised bench for i2s_transmitter (WIDTH=16, CLK_DIV=4). The
// reference model works from cycle counts since reset release: falling edges
// every 2*CLK_DIV cycles, frames every 128*CLK_DIV cycles, plus a one-entry
// buffer model for the handshake.
// -----------------------------------------------------------------------------
module tb_i2s_transmitter;

    localparam int WIDTH   = 16;
    localparam int CLK_DIV = 4;
    localparam int HALF    = CLK_DIV;
    localparam int EVT     = 2 * CLK_DIV;
    localparam int FRAME   = 128 * CLK_DIV;

    logic             clk_in   = 1'b0;
    logic             rst_in   = 1'b0;
    logic [WIDTH-1:0] left_in  = '0;
    logic [WIDTH-1:0] right_in = '0;
    logic             valid_in = 1'b0;
    logic             ready_out;
    logic             sclk_out;
    logic             ws_out;
    logic             sdata_out;
    logic             frame_start_out;
    logic             underrun_out;

    i2s_transmitter #(
        .WIDTH   (WIDTH),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .left_in         (left_in),
        .right_in        (right_in),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .sclk_out        (sclk_out),
        .ws_out          (ws_out),
        .sdata_out       (sdata_out),
        .frame_start_out (frame_start_out),
        .underrun_out    (underrun_out)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          n = 0;
    logic        m_full = 1'b0;
    logic [15:0] m_l = '0, m_r = '0;
    logic [15:0] cur_l = '0, cur_r = '0;
    logic        exp_fs = 1'b0, exp_ur = 1'b0, last_acc = 1'b0;

    // Receiver model
    logic [15:0] rx_l = '0, rx_r = '0;
    logic        prev_sclk = 1'b0;
    int          ur_seen = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s n=%0d observed=%0b expected=%0b", tag, n, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s n=%0d observed=%04h expected=%04h", tag, n, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, exp);
        end
    endtask

    function automatic int model_p();
        int k;
        k = n / EVT;
        return (k == 0) ? 63 : (k - 1) % 64;
    endfunction

    // One clock: advance the model with the inputs present at the edge, then
    // compare every output 1 time unit later.
    task automatic tick();
        int   p;
        logic exp_sd;
        @(posedge clk_in);
        if (!rst_in) begin
            n = 0; m_full = 1'b0; cur_l = '0; cur_r = '0;
            exp_fs = 1'b0; exp_ur = 1'b0; last_acc = 1'b0;
        end else begin
            n++;
            exp_fs   = (n >= EVT) && (((n - EVT) % FRAME) == 0);
            exp_ur   = exp_fs && !m_full;
            last_acc = valid_in && !m_full;
            if (exp_fs) begin
                cur_l  = m_full ? m_l : 16'h0000;
                cur_r  = m_full ? m_r : 16'h0000;
                m_full = 1'b0;
            end
            if (last_acc) begin
                m_l = left_in; m_r = right_in; m_full = 1'b1;
            end
        end
        #1;
        p = model_p();
        exp_sd = 1'b0;
        if (p < 16)                 exp_sd = cur_l[4'(15 - p)];
        else if (p >= 32 && p < 48) exp_sd = cur_r[4'(47 - p)];
        chk1("ready", ready_out, !m_full);
        chk1("sclk", sclk_out, ((n / HALF) % 2) == 1);
        chk1("ws", ws_out, (p >= 31) && (p <= 62));
        chk1("sdata", sdata_out, exp_sd);
        chk1("frame_start", frame_start_out, exp_fs);
        chk1("underrun", underrun_out, exp_ur);
        if (!prev_sclk && sclk_out) begin
            if (p < 16)                 rx_l = {rx_l[14:0], sdata_out};
            else if (p >= 32 && p < 48) rx_r = {rx_r[14:0], sdata_out};
        end
        prev_sclk = sclk_out;
        if (underrun_out) ur_seen++;
    endtask

    task automatic run_until_fs();
        int i;
        i = 0;
        do begin
            tick();
            i++;
        end while (!frame_start_out && i < FRAME + EVT + 4);
        chk1("frame_start_wait", frame_start_out, 1'b1);
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r);
        int i;
        i = 0;
        left_in = l; right_in = r; valid_in = 1'b1;
        do begin
            tick();
            i++;
        end while (!last_acc && i < 16);
        valid_in = 1'b0;
        chk1("ready_after_offer", ready_out, 1'b0);
    endtask

    initial begin
        logic [15:0] base;
        int          idx;

        // Reset values
        repeat (3) tick();

        // Pair accepted before the first frame; first frame 2*CLK_DIV after release
        rst_in = 1'b1;
        offer(16'hA5C3, 16'h5A3C);
        run_until_fs();
        chkint("first_frame_cycle", n, EVT);
        chk1("first_frame_no_underrun", underrun_out, 1'b0);
        repeat (60 * EVT) tick();
        chk16("rx_left", rx_l, 16'hA5C3);
        chk16("rx_right", rx_r, 16'h5A3C);
        run_until_fs();
        chk1("empty_frame_underrun", underrun_out, 1'b1);

        // Continuous valid: one accept per frame, incrementing pairs
        base = 16'($urandom);
        idx = 0;
        left_in = base; right_in = ~base; valid_in = 1'b1;
        repeat (4 * FRAME - 2) begin
            tick();
            if (last_acc) begin
                idx++;
                left_in  = base + 16'(idx);
                right_in = ~left_in;
            end
        end
        valid_in = 1'b0;
        chkint("accepts_in_4_frames", idx, 4);

        // Alternate data frames and silent frames
        run_until_fs();
        ur_seen = 0;
        for (int f = 0; f < 4; f++) begin
            if (f % 2 == 0) offer(16'($urandom), 16'($urandom));
            run_until_fs();
            chk1("alt_underrun", underrun_out, (f % 2) == 1);
        end
        chkint("alt_underrun_count", ur_seen, 2);

        // Asynchronous reset at position 20 of a loaded frame
        offer(16'($urandom) | 16'h8000, 16'($urandom));
        run_until_fs();
        repeat (20 * EVT) tick();
        #2;
        rst_in = 1'b0;
        #1;
        chk1("arst_sclk", sclk_out, 1'b0);
        chk1("arst_ws", ws_out, 1'b0);
        chk1("arst_sdata", sdata_out, 1'b0);
        chk1("arst_fs", frame_start_out, 1'b0);
        chk1("arst_ur", underrun_out, 1'b0);
        chk1("arst_ready", ready_out, 1'b1);
        n = 0; m_full = 1'b0; cur_l = '0; cur_r = '0;
        exp_fs = 1'b0; exp_ur = 1'b0;
        repeat (2) tick();
        rst_in = 1'b1;

        // After release: silent frames with underrun at 2*CLK_DIV, then every frame
        run_until_fs();
        chkint("post_reset_first_frame", n, EVT);
        chk1("post_reset_underrun", underrun_out, 1'b1);
        run_until_fs();
        chkint("post_reset_second_frame", n, EVT + FRAME);
        chk1("post_reset_underrun2", underrun_out, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001: Parameter WIDTH, default 16, bits per channel sample (1..32).
REQ-002: Parameter CLK_DIV, default 32, clk_in cycles per sclk half-period (>=2).
REQ-003: clk_in  input  1  system clock (100 MHz).
REQ-004: rst_in  input  1  reset; asynchronous, active-low.
REQ-005: left_in  input  WIDTH  left sample, two's complement.
REQ-006: right_in  input  WIDTH  right sample, two's complement.
REQ-007: valid_in  input  1  left_in/right_in pair offered.
REQ-008: ready_out  output  1  holding buffer empty; pair accepted when valid_in && ready_out.
REQ-009: sclk_out  output  1  I2S bit clock.
REQ-010: ws_out  output  1  I2S word select; 0 = left, 1 = right.
REQ-011: sdata_out  output  1  I2S serial data, MSB first.
REQ-012: frame_start_out  output  1  one-cycle pulse when a frame begins (bit position 0).
REQ-013: underrun_out  output  1  one-cycle pulse when a frame begins with an empty holding buffer.

Function
REQ-014: div_cnt counts 0..CLK_DIV-1 on every clk_in; at CLK_DIV-1 it wraps to 0 and sclk_out toggles.
REQ-015: A falling-edge event is the cycle sclk_out toggles 1->0; bit position p (0..63) advances by 1 (63 wraps to 0) on each falling-edge event.
REQ-016: Frame = 64 sclk periods; left slot p=0..31, right slot p=32..63.
REQ-017: ws_out, sdata_out, and p update only on falling-edge events; all three registered.
REQ-018: ws_out = 1 for p in 31..62, else 0 (ws leads each channel MSB by one sclk).
REQ-019: sdata_out = left bit [WIDTH-1-p] for p < WIDTH; right bit [WIDTH-1-(p-32)] for 32 <= p < 32+WIDTH; 0 for all other p.
REQ-020: Holding buffer: hold_l, hold_r, hold_full; ready_out = !hold_full (registered state, no combinational path from valid_in).
REQ-021: On valid_in && ready_out, capture left_in/right_in into the buffer and set hold_full next cycle.
REQ-022: On falling-edge event with p 63->0 and hold_full=1: copy buffer into left/right shift registers, clear hold_full, pulse frame_start_out.
REQ-023: Same event with hold_full=0: load zeros into both shift registers, pulse frame_start_out and underrun_out.
REQ-024: Buffer load and a new accept never coincide: load cycle has ready_out=0; the next pair is accepted no earlier than the following cycle.
REQ-025: A frame in progress always completes with the data loaded at its p=0; new accepts do not alter the current frame.
REQ-026: Output sample rate = f_clk / (128*CLK_DIV); 100 MHz, CLK_DIV=32 -> 24.414 kHz.

Reset
REQ-027: While rst_in=0: sclk_out=0, ws_out=0, sdata_out=0, frame_start_out=0, underrun_out=0, div_cnt=0, p=63, hold_full=0 (ready_out=1), shift registers=0.
REQ-028: Reset assertion mid-frame aborts immediately and discards buffered/shifting data; no partial word completes after release.
REQ-029: After release, the first falling-edge event occurs 2*CLK_DIV cycles later and starts frame p=0.

Verification
REQ-030: CLK_DIV=4, WIDTH=16; release reset, no valid_in -> sclk period 8 cycles, frame_start_out and underrun_out pulse at cycle 8 then every 512 cycles; sdata_out stays 0.
REQ-031: Accept left=16'hA5C3, right=16'h5A3C before first frame -> left slot bits 1010010111000011 then 16 zeros; right slot 0101101000111100 then 16 zeros; no underrun.
REQ-032: Check ws_out: rises at falling edge of p=31, falls at p=63; receiver-model decode on sclk rising edges returns 16'hA5C3/16'h5A3C.
REQ-033: Hold valid_in=1 with incrementing pairs -> exactly one accept per frame, ready_out low from accept until load, no skipped or duplicated pair, no underrun.
REQ-034: Assert rst_in=0 at p=20 of a loaded frame -> all outputs 0 within the same cycle (async), ready_out=1 after release, next frame underruns.
REQ-035: Supply only every other frame -> alternating data frames and zero frames, underrun_out pulse on each zero frame.
